sap_reg_bank: RTL and testbench

//  Parametrised general-purpose register bank for the SAP datapath.

---
 rtl/sap_pkg.sv | 28 ++
 rtl/sap_reg_cell.sv | 60 ++++++
 rtl/sap_reg_bank.sv | 68 ++++++
 tb/tb_sap_reg_bank.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP datapath: default bus width and register-bank op codes.
package sap_pkg;

  localparam int SAP_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_CLR  = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_RSVD = 3'd7
  } op_t;

  // Ops that modify the addressed register (and therefore the zero flag).
  function automatic logic op_writes(input op_t op);
    return (op == OP_LOAD) || (op == OP_CLR) || (op == OP_INC) ||
           (op == OP_DEC)  || (op == OP_SHL) || (op == OP_SHR);
  endfunction

  // Ops that produce a carry/borrow/shifted-out bit.
  function automatic logic op_sets_carry(input op_t op);
    return (op == OP_INC) || (op == OP_DEC) || (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/sap_reg_cell.sv
// One WIDTH-bit register of the SAP bank with its load/clear/inc/dec/shift logic.
module sap_reg_cell
  import sap_pkg::*;
#(
  parameter int WIDTH = SAP_WIDTH
) (
  input  logic             Clock,
  input  logic             reset_n,
  input  logic             we,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_bus,
  output logic [WIDTH-1:0] q,
  output logic             carry,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  op_t              op_e;
  logic [WIDTH-1:0] nxt;

  assign op_e = op_t'(op);

  always_comb begin
    nxt   = q;
    carry = 1'b0;
    case (op_e)
      OP_LOAD: nxt = data_bus;
      OP_CLR:  nxt = '0;
      OP_INC: begin
        nxt   = q + ONE;
        carry = &q;
      end
      OP_DEC: begin
        nxt   = q - ONE;
        carry = ~|q;
      end
      OP_SHL: begin
        nxt   = {q[WIDTH-2:0], 1'b0};
        carry = q[WIDTH-1];
      end
      OP_SHR: begin
        nxt   = {1'b0, q[WIDTH-1:1]};
        carry = q[0];
      end
      default: nxt = q;
    endcase
  end

  assign zero = ~|nxt;

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (we) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/sap_reg_bank.sv
// SAP register bank: DEPTH op-capable registers, two ALU read ports, one muxed bus port, zero/carry flags.
module sap_reg_bank
  import sap_pkg::*;
#(
  parameter  int WIDTH = SAP_WIDTH,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_bus,
  input  logic [AW-1:0]    wr_addr,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  input  logic [AW-1:0]    rd_addr_o,
  input  logic             out_enable,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_valid,
  output logic             zero_flag,
  output logic             carry_flag
);

  op_t              op_e;
  logic             wr_any;
  logic [WIDTH-1:0] q_arr [DEPTH];
  logic [DEPTH-1:0] cy_vec;
  logic [DEPTH-1:0] z_vec;

  assign op_e   = op_t'(op);
  assign wr_any = op_writes(op_e);

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    sap_reg_cell #(.WIDTH(WIDTH)) u_cell (
      .Clock    (Clock),
      .reset_n  (reset_n),
      .we       (wr_any && (wr_addr == AW'(i))),
      .op       (op),
      .data_bus (data_bus),
      .q        (q_arr[i]),
      .carry    (cy_vec[i]),
      .zero     (z_vec[i])
    );
  end

  // Read paths are pure muxes on register state: a same-cycle write is not bypassed.
  assign alu_a     = q_arr[rd_addr_a];
  assign alu_b     = q_arr[rd_addr_b];
  assign bus_out   = out_enable ? q_arr[rd_addr_o] : '0;
  assign bus_valid = out_enable;

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      if (wr_any) begin
        zero_flag <= z_vec[wr_addr];
      end
      if (op_sets_carry(op_e)) begin
        carry_flag <= cy_vec[wr_addr];
      end
    end
  end

endmodule

// File: tb/tb_sap_reg_bank.sv
// Bench driving an 8-bit/4-deep and a 16-bit/8-deep bank in lockstep against an arithmetic reference model.
module tb_sap_reg_bank;

  logic        Clock = 1'b0;
  logic        reset_n;
  logic [15:0] data_bus;
  logic [2:0]  wr_addr, op, rd_a, rd_b, rd_o;
  logic        oe;

  logic [7:0]  a8, b8, o8;
  logic        v8, z8, c8;
  logic [15:0] a16, b16, o16;
  logic        v16, z16, c16;

  always #5 Clock = ~Clock;

  sap_reg_bank #(.WIDTH(8), .DEPTH(4)) dut8 (
    .Clock(Clock), .reset_n(reset_n), .data_bus(data_bus[7:0]), .wr_addr(wr_addr[1:0]),
    .op(op), .rd_addr_a(rd_a[1:0]), .rd_addr_b(rd_b[1:0]), .rd_addr_o(rd_o[1:0]),
    .out_enable(oe), .alu_a(a8), .alu_b(b8), .bus_out(o8), .bus_valid(v8),
    .zero_flag(z8), .carry_flag(c8)
  );

  sap_reg_bank #(.WIDTH(16), .DEPTH(8)) dut16 (
    .Clock(Clock), .reset_n(reset_n), .data_bus(data_bus), .wr_addr(wr_addr),
    .op(op), .rd_addr_a(rd_a), .rd_addr_b(rd_b), .rd_addr_o(rd_o),
    .out_enable(oe), .alu_a(a16), .alu_b(b16), .bus_out(o16), .bus_valid(v16),
    .zero_flag(z16), .carry_flag(c16)
  );

  logic [15:0] o_a [2];
  logic [15:0] o_b [2];
  logic [15:0] o_o [2];
  logic        o_v [2];
  logic        o_z [2];
  logic        o_c [2];

  assign o_a[0] = {8'h00, a8};
  assign o_b[0] = {8'h00, b8};
  assign o_o[0] = {8'h00, o8};
  assign o_v[0] = v8;
  assign o_z[0] = z8;
  assign o_c[0] = c8;
  assign o_a[1] = a16;
  assign o_b[1] = b16;
  assign o_o[1] = o16;
  assign o_v[1] = v16;
  assign o_z[1] = z16;
  assign o_c[1] = c16;

  int errors = 0;
  int checks = 0;

  // Reference state: index 0 = 8-bit bank, index 1 = 16-bit bank.
  logic [15:0] m [2][8];
  logic        mz [2];
  logic        mc [2];

  function automatic int unsigned mask(input int k);
    return (k == 0) ? 32'h00FF : 32'hFFFF;
  endfunction

  function automatic int am(input int k);
    return (k == 0) ? 3 : 7;
  endfunction

  function automatic logic [15:0] exp_rd(input int k, input int a);
    return m[k][a & am(k)];
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 8; r++) m[k][r] = '0;
      mz[k] = 1'b0;
      mc[k] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    for (int k = 0; k < 2; k++) begin
      int          w;
      int          adr;
      int unsigned ov, nv, mk;
      bit          cy;
      w   = (k == 0) ? 8 : 16;
      mk  = mask(k);
      adr = int'(wr_addr) & am(k);
      ov  = m[k][adr];
      nv  = ov;
      cy  = 1'b0;
      case (op)
        3'd1: nv = data_bus & mk;
        3'd2: nv = 0;
        3'd3: begin nv = (ov + 1) % (mk + 1); cy = (ov == mk); end
        3'd4: begin nv = (ov == 0) ? mk : ov - 1; cy = (ov == 0); end
        3'd5: begin nv = (ov * 2) % (mk + 1); cy = ((ov >> (w - 1)) & 1) != 0; end
        3'd6: begin nv = ov / 2; cy = (ov % 2) != 0; end
        default: nv = ov;
      endcase
      if (op >= 3'd1 && op <= 3'd6) begin
        m[k][adr] = nv[15:0];
        mz[k]     = (nv == 0);
      end
      if (op >= 3'd3 && op <= 3'd6) mc[k] = cy;
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    // Reset state right after power-up reset.
    op = 3'd0;
    for (int i = 0; i < 8; i++) begin
      rd_a = 3'(i);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_a[k] !== 16'h0000) begin
          errors++;
          $display("FAIL reset_init_reg dut%0d r%0d got %h want 0000", k, i, o_a[k]);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_z[k] !== 1'b0 || o_c[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_init_flags dut%0d got z=%b c=%b want z=0 c=0", k, o_z[k], o_c[k]);
      end
    end
    // Populate registers, then leave zero=1 and carry=1.
    for (int i = 0; i < 8; i++) begin
      op = 3'd1; wr_addr = 3'(i); data_bus = 16'($urandom) | 16'h0101;
      tick();
    end
    op = 3'd1; wr_addr = 3'd0; data_bus = 16'hFFFF; tick();
    op = 3'd3; tick();
    op = 3'd2; wr_addr = 3'd2; tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_z[k] !== 1'b1 || o_c[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset_prep_flags dut%0d got z=%b c=%b want z=1 c=1", k, o_z[k], o_c[k]);
      end
    end
    // Asynchronous reset mid-cycle with a load pending.
    op = 3'd1; wr_addr = 3'd1; data_bus = 16'h1234;
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_z[k] !== 1'b0 || o_c[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_async_flags dut%0d got z=%b c=%b want z=0 c=0", k, o_z[k], o_c[k]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      rd_a = 3'(i);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_a[k] !== 16'h0000) begin
          errors++;
          $display("FAIL reset_async_reg dut%0d r%0d got %h want 0000", k, i, o_a[k]);
        end
      end
    end
    @(posedge Clock);
    #1;
    rd_a = 3'd1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_a[k] !== 16'h0000 || o_z[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold dut%0d got r1=%h z=%b want r1=0000 z=0", k, o_a[k], o_z[k]);
      end
    end
    op = 3'd0;
    reset_n = 1'b1;
    #2;
  endtask

  task automatic test_load_read();
    op = 3'd1; wr_addr = 3'd2; data_bus = 16'h00A5;
    tick();
    op = 3'd0; rd_a = 3'd2; rd_b = 3'd2; rd_o = 3'd2; oe = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_a[k] !== 16'h00A5 || o_b[k] !== 16'h00A5 || o_o[k] !== 16'h00A5) begin
        errors++;
        $display("FAIL load_read dut%0d got a=%h b=%h o=%h want 00a5", k, o_a[k], o_b[k], o_o[k]);
      end
      checks++;
      if (o_v[k] !== 1'b1 || o_z[k] !== 1'b0) begin
        errors++;
        $display("FAIL load_flags dut%0d got valid=%b z=%b want valid=1 z=0", k, o_v[k], o_z[k]);
      end
    end
  endtask

  task automatic test_inc_dec();
    op = 3'd1; wr_addr = 3'd1; data_bus = 16'hFFFF; tick();
    op = 3'd3; tick();
    op = 3'd0; rd_a = 3'd1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_a[k] !== 16'h0000 || o_z[k] !== 1'b1 || o_c[k] !== 1'b1) begin
        errors++;
        $display("FAIL inc_wrap dut%0d got r=%h z=%b c=%b want r=0000 z=1 c=1", k, o_a[k], o_z[k], o_c[k]);
      end
    end
    op = 3'd4; tick();
    op = 3'd0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_a[k] !== 16'(mask(k)) || o_z[k] !== 1'b0 || o_c[k] !== 1'b1) begin
        errors++;
        $display("FAIL dec_wrap dut%0d got r=%h z=%b c=%b want r=%h z=0 c=1", k, o_a[k], o_z[k], o_c[k], 16'(mask(k)));
      end
    end
  endtask

  task automatic test_shift();
    logic [15:0] e_shl [2];
    logic [15:0] e_shr [2];
    e_shl[0] = 16'h0002; e_shl[1] = 16'h0102;
    e_shr[0] = 16'h0001; e_shr[1] = 16'h0081;
    op = 3'd1; wr_addr = 3'd0; data_bus = 16'h8081; tick();
    rd_a = 3'd0;
    op = 3'd5; tick();
    op = 3'd0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_a[k] !== e_shl[k] || o_c[k] !== 1'b1 || o_z[k] !== 1'b0) begin
        errors++;
        $display("FAIL shl dut%0d got r=%h c=%b z=%b want r=%h c=1 z=0", k, o_a[k], o_c[k], o_z[k], e_shl[k]);
      end
    end
    op = 3'd6; tick();
    op = 3'd0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_a[k] !== e_shr[k] || o_c[k] !== 1'b0) begin
        errors++;
        $display("FAIL shr dut%0d got r=%h c=%b want r=%h c=0", k, o_a[k], o_c[k], e_shr[k]);
      end
    end
    // Shift the low bit out so carry=1, then check LOAD leaves it alone.
    op = 3'd6; tick();
    op = 3'd1; data_bus = 16'h0000; tick();
    op = 3'd0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_a[k] !== 16'h0000 || o_z[k] !== 1'b1 || o_c[k] !== 1'b1) begin
        errors++;
        $display("FAIL load_zero dut%0d got r=%h z=%b c=%b want r=0000 z=1 c=1", k, o_a[k], o_z[k], o_c[k]);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [15:0] old [2];
    op = 3'd1; wr_addr = 3'd3; data_bus = 16'h003C; rd_a = 3'd3;
    #1;
    for (int k = 0; k < 2; k++) begin
      old[k] = exp_rd(k, 3);
      checks++;
      if (o_a[k] !== old[k]) begin
        errors++;
        $display("FAIL same_cycle_old dut%0d got %h want %h", k, o_a[k], old[k]);
      end
    end
    tick();
    op = 3'd0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_a[k] !== 16'h003C) begin
        errors++;
        $display("FAIL same_cycle_new dut%0d got %h want 003c", k, o_a[k]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      rd_b = 3'(i);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_b[k] !== exp_rd(k, i)) begin
          errors++;
          $display("FAIL same_cycle_others dut%0d r%0d got %h want %h", k, i, o_b[k], exp_rd(k, i));
        end
      end
    end
  endtask

  task automatic test_out_enable();
    oe = 1'b0;
    for (int n = 0; n < 6; n++) begin
      rd_o = 3'($urandom_range(0, 7));
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_o[k] !== 16'h0000 || o_v[k] !== 1'b0) begin
          errors++;
          $display("FAIL out_disable dut%0d addr=%0d got bus=%h valid=%b want bus=0000 valid=0", k, rd_o, o_o[k], o_v[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      op       = 3'($urandom_range(0, 7));
      wr_addr  = 3'($urandom_range(0, 7));
      data_bus = 16'($urandom);
      if (($urandom & 7) == 0) data_bus = 16'h0000;
      rd_a = 3'($urandom_range(0, 7));
      rd_b = 3'($urandom_range(0, 7));
      rd_o = ($urandom & 1) ? wr_addr : 3'($urandom_range(0, 7));
      oe   = 1'($urandom);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_a[k] !== exp_rd(k, rd_a) || o_b[k] !== exp_rd(k, rd_b) ||
            o_o[k] !== (oe ? exp_rd(k, rd_o) : 16'h0000) || o_v[k] !== oe) begin
          errors++;
          $display("FAIL rand_pre dut%0d n=%0d got a=%h b=%h o=%h v=%b want a=%h b=%h o=%h v=%b",
                   k, n, o_a[k], o_b[k], o_o[k], o_v[k], exp_rd(k, rd_a), exp_rd(k, rd_b),
                   oe ? exp_rd(k, rd_o) : 16'h0000, oe);
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_a[k] !== exp_rd(k, rd_a) || o_b[k] !== exp_rd(k, rd_b) ||
            o_o[k] !== (oe ? exp_rd(k, rd_o) : 16'h0000) ||
            o_z[k] !== mz[k] || o_c[k] !== mc[k]) begin
          errors++;
          $display("FAIL rand_post dut%0d n=%0d op=%0d got a=%h b=%h o=%h z=%b c=%b want a=%h b=%h o=%h z=%b c=%b",
                   k, n, op, o_a[k], o_b[k], o_o[k], o_z[k], o_c[k], exp_rd(k, rd_a), exp_rd(k, rd_b),
                   oe ? exp_rd(k, rd_o) : 16'h0000, mz[k], mc[k]);
        end
      end
    end
    op = 3'd0;
  endtask

  initial begin
    reset_n  = 1'b0;
    data_bus = '0;
    wr_addr  = '0;
    op       = '0;
    rd_a     = '0;
    rd_b     = '0;
    rd_o     = '0;
    oe       = 1'b0;
    model_reset();
    repeat (2) @(posedge Clock);
    #1;
    reset_n = 1'b1;
    test_reset();
    test_load_read();
    test_inc_dec();
    test_shift();
    test_same_cycle();
    test_out_enable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
